// File: rtl/frame_buf_mgr.sv
`default_nettype none
// ============================================================================
// frame_buf_mgr : buffer ownership manager between one frame writer and one
//                 reader; FRAME_BUF_STAT_EN adds saturating drop/repeat counters.
// Revision      : 1.0
// ============================================================================
module frame_buf_mgr #(
  parameter int unsigned           BUF_NUM      = 3,
  parameter int unsigned           ADDR_BITS    = 24,
  parameter logic [ADDR_BITS-1:0]  BASE_ADDR    = 24'd0,
  parameter logic [ADDR_BITS-1:0]  FRAME_STRIDE = 24'd2073600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_start,
  input  logic                 wr_done,
  output logic                 wr_ack,
  output logic [2:0]           wr_index,
  output logic [ADDR_BITS-1:0] wr_addr,
  input  logic                 rd_start,
  output logic                 rd_ack,
  output logic [2:0]           rd_index,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_valid,
  input  logic                 freeze
`ifdef FRAME_BUF_STAT_EN
  ,
  output logic [15:0]          drop_cnt,
  output logic [15:0]          repeat_cnt
`endif
);

  typedef enum logic [0:0] {
    W_IDLE   = 1'b0,
    W_ACTIVE = 1'b1
  } wstate_t;

  localparam logic [2:0] c_LAST_IDX = 3'(BUF_NUM - 1);

  function automatic logic [ADDR_BITS-1:0] addr_of(input logic [2:0] idx);
    logic [ADDR_BITS-1:0] w_idx_ext;
    w_idx_ext = ADDR_BITS'(idx);
    return BASE_ADDR + w_idx_ext * FRAME_STRIDE;
  endfunction

  wstate_t              r_state, w_state_nxt;
  logic [2:0]           r_wr_idx, w_wr_nxt;
  logic [2:0]           r_rd_idx, w_rd_nxt;
  logic [2:0]           r_ready_idx, w_rdy_nxt;
  logic                 r_ready_flag, w_flag_nxt;
  logic                 r_rd_valid, w_valid_nxt;
  logic                 r_wr_ack, r_rd_ack;
  logic [ADDR_BITS-1:0] r_wr_addr, r_rd_addr;
  logic                 w_publish;
  logic                 w_found;
  logic [2:0]           w_pick;

  assign w_publish = wr_done && (r_state == W_ACTIVE) && !freeze;

  // Ordering within one cycle: completion, then reader hand-off, then allocation.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = r_wr_idx;
    w_rd_nxt    = r_rd_idx;
    w_rdy_nxt   = r_ready_idx;
    w_flag_nxt  = r_ready_flag;
    w_valid_nxt = r_rd_valid;
    w_found     = 1'b0;
    w_pick      = 3'd0;

    if (wr_done && (r_state == W_ACTIVE)) begin
      w_state_nxt = W_IDLE;
      if (!freeze) begin
        w_rdy_nxt   = r_wr_idx;
        w_flag_nxt  = 1'b1;
        w_valid_nxt = 1'b1;
      end
    end

    if (rd_start && w_flag_nxt) begin
      w_rd_nxt   = w_rdy_nxt;
      w_flag_nxt = 1'b0;
    end

    if (wr_start) begin
      // Descending scan so the lowest qualifying index is the one kept.
      for (int i = int'(BUF_NUM) - 1; i >= 0; i--) begin
        if ((3'(i) != w_rd_nxt) && !(w_flag_nxt && (3'(i) == w_rdy_nxt))) begin
          w_found = 1'b1;
          w_pick  = 3'(i);
        end
      end
      if (!w_found) begin
        w_pick     = w_rdy_nxt;
        w_flag_nxt = 1'b0;
      end
      w_wr_nxt    = w_pick;
      w_state_nxt = W_ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= W_IDLE;
      r_wr_idx     <= 3'd0;
      r_rd_idx     <= c_LAST_IDX;
      r_ready_idx  <= 3'd0;
      r_ready_flag <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_rd_ack     <= 1'b0;
      r_wr_addr    <= BASE_ADDR;
      r_rd_addr    <= addr_of(c_LAST_IDX);
    end else begin
      r_state      <= w_state_nxt;
      r_wr_idx     <= w_wr_nxt;
      r_rd_idx     <= w_rd_nxt;
      r_ready_idx  <= w_rdy_nxt;
      r_ready_flag <= w_flag_nxt;
      r_rd_valid   <= w_valid_nxt;
      r_wr_ack     <= wr_start;
      r_rd_ack     <= rd_start;
      if (wr_start) r_wr_addr <= addr_of(w_wr_nxt);
      if (rd_start) r_rd_addr <= addr_of(w_rd_nxt);
    end
  end

  assign wr_ack   = r_wr_ack;
  assign wr_index = r_wr_idx;
  assign wr_addr  = r_wr_addr;
  assign rd_ack   = r_rd_ack;
  assign rd_index = r_rd_idx;
  assign rd_addr  = r_rd_addr;
  assign rd_valid = r_rd_valid;

`ifdef FRAME_BUF_STAT_EN
  logic        w_ev_overwrite, w_ev_discard, w_ev_abandon, w_ev_steal, w_ev_repeat;
  logic [1:0]  w_drop_inc;
  logic [16:0] w_drop_sum, w_rep_sum;
  logic [15:0] r_drop_cnt, r_rep_cnt;

  // At most two drop events can coincide (completion-side plus allocation-side).
  assign w_ev_overwrite = w_publish && r_ready_flag;
  assign w_ev_discard   = wr_done && (r_state == W_ACTIVE) && freeze;
  assign w_ev_abandon   = wr_start && (r_state == W_ACTIVE) && !wr_done;
  assign w_ev_steal     = wr_start && !w_found;
  assign w_ev_repeat    = rd_start && !(r_ready_flag || w_publish);
  assign w_drop_inc     = 2'(w_ev_overwrite) + 2'(w_ev_discard) + 2'(w_ev_abandon) + 2'(w_ev_steal);
  assign w_drop_sum     = 17'(r_drop_cnt) + 17'(w_drop_inc);
  assign w_rep_sum      = 17'(r_rep_cnt) + 17'(w_ev_repeat);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 16'd0;
      r_rep_cnt  <= 16'd0;
    end else begin
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      r_rep_cnt  <= w_rep_sum[16]  ? 16'hFFFF : w_rep_sum[15:0];
    end
  end

  assign drop_cnt   = r_drop_cnt;
  assign repeat_cnt = r_rep_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_mgr.sv
`default_nettype none
// ============================================================================
// tb_frame_buf_mgr : directed bench for frame_buf_mgr (BUF_NUM=3 and BUF_NUM=2
//                    instances) against a queue-free reference model.
// Revision         : 1.0
// ============================================================================
module tb_frame_buf_mgr;

  localparam int unsigned          AW = 24;
  localparam logic [AW-1:0]        c_B3 = 24'd0;
  localparam logic [AW-1:0]        c_S3 = 24'd2073600;
  localparam logic [AW-1:0]        c_B2 = 24'h100000;
  localparam logic [AW-1:0]        c_S2 = 24'hF00000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_start = 1'b0;
  logic wr_done = 1'b0;
  logic rd_start = 1'b0;
  logic freeze = 1'b0;

  logic          a_wr_ack   [2];
  logic [2:0]    a_wr_index [2];
  logic [AW-1:0] a_wr_addr  [2];
  logic          a_rd_ack   [2];
  logic [2:0]    a_rd_index [2];
  logic [AW-1:0] a_rd_addr  [2];
  logic          a_rd_valid [2];
`ifdef FRAME_BUF_STAT_EN
  logic [15:0]   a_drop [2];
  logic [15:0]   a_rep  [2];
`endif

  always #5 clk = ~clk;

  frame_buf_mgr #(.BUF_NUM(3), .ADDR_BITS(AW), .BASE_ADDR(c_B3), .FRAME_STRIDE(c_S3)) u_dut3 (
    .clk(clk), .rst(rst), .wr_start(wr_start), .wr_done(wr_done),
    .wr_ack(a_wr_ack[0]), .wr_index(a_wr_index[0]), .wr_addr(a_wr_addr[0]),
    .rd_start(rd_start), .rd_ack(a_rd_ack[0]), .rd_index(a_rd_index[0]),
    .rd_addr(a_rd_addr[0]), .rd_valid(a_rd_valid[0]), .freeze(freeze)
`ifdef FRAME_BUF_STAT_EN
    , .drop_cnt(a_drop[0]), .repeat_cnt(a_rep[0])
`endif
  );

  frame_buf_mgr #(.BUF_NUM(2), .ADDR_BITS(AW), .BASE_ADDR(c_B2), .FRAME_STRIDE(c_S2)) u_dut2 (
    .clk(clk), .rst(rst), .wr_start(wr_start), .wr_done(wr_done),
    .wr_ack(a_wr_ack[1]), .wr_index(a_wr_index[1]), .wr_addr(a_wr_addr[1]),
    .rd_start(rd_start), .rd_ack(a_rd_ack[1]), .rd_index(a_rd_index[1]),
    .rd_addr(a_rd_addr[1]), .rd_valid(a_rd_valid[1]), .freeze(freeze)
`ifdef FRAME_BUF_STAT_EN
    , .drop_cnt(a_drop[1]), .repeat_cnt(a_rep[1])
`endif
  );

  // Reference model state, one slot per instance (0: three buffers, 1: two buffers)
  int     m_n      [2] = '{3, 2};
  longint m_base   [2] = '{0, 64'h100000};
  longint m_stride [2] = '{2073600, 64'hF00000};
  int     m_wr [2], m_rd [2], m_rdy [2], m_drop [2], m_rep [2];
  bit     m_flag [2], m_act [2], m_valid [2], m_wack [2], m_rack [2];
  bit     started = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic longint exp_addr(input int k, input int idx);
    return (m_base[k] + longint'(idx) * m_stride[k]) % 64'h1000000;
  endfunction

  task automatic check(input string nm, input int k, input longint act, input longint want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, k, act, want, $time);
    end
  endtask

  task automatic bump_drop(input int k);
    if (m_drop[k] < 65535) m_drop[k]++;
  endtask

  task automatic step(input int k);
    int pick;
    if (rst) begin
      m_wr[k] = 0; m_rd[k] = m_n[k] - 1; m_rdy[k] = 0; m_flag[k] = 0; m_act[k] = 0;
      m_valid[k] = 0; m_wack[k] = 0; m_rack[k] = 0; m_drop[k] = 0; m_rep[k] = 0;
      return;
    end
    m_wack[k] = wr_start;
    m_rack[k] = rd_start;
    if (wr_done && m_act[k]) begin
      m_act[k] = 0;
      if (freeze) bump_drop(k);
      else begin
        if (m_flag[k]) bump_drop(k);
        m_rdy[k] = m_wr[k]; m_flag[k] = 1; m_valid[k] = 1;
      end
    end
    if (rd_start) begin
      if (m_flag[k]) begin
        m_rd[k] = m_rdy[k]; m_flag[k] = 0;
      end else if (m_rep[k] < 65535) m_rep[k]++;
    end
    if (wr_start) begin
      if (m_act[k]) bump_drop(k);
      pick = -1;
      for (int i = 0; i < m_n[k]; i++)
        if (pick < 0 && i != m_rd[k] && !(m_flag[k] && i == m_rdy[k])) pick = i;
      if (pick < 0) begin
        pick = m_rdy[k]; m_flag[k] = 0; bump_drop(k);
      end
      m_wr[k] = pick; m_act[k] = 1;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) step(k);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        check("wr_ack",   k, a_wr_ack[k],   m_wack[k]);
        check("wr_index", k, a_wr_index[k], m_wr[k]);
        check("wr_addr",  k, a_wr_addr[k],  exp_addr(k, m_wr[k]));
        check("rd_ack",   k, a_rd_ack[k],   m_rack[k]);
        check("rd_index", k, a_rd_index[k], m_rd[k]);
        check("rd_addr",  k, a_rd_addr[k],  exp_addr(k, m_rd[k]));
        check("rd_valid", k, a_rd_valid[k], m_valid[k]);
        if (m_act[k]) check("wr_ne_rd", k, a_wr_index[k] != a_rd_index[k], 1);
`ifdef FRAME_BUF_STAT_EN
        check("drop_cnt",   k, a_drop[k], m_drop[k]);
        check("repeat_cnt", k, a_rep[k],  m_rep[k]);
`endif
      end
    end
  end

  task automatic cyc(input bit ws, input bit wd, input bit rs);
    wr_start = ws; wr_done = wd; rd_start = rs;
    @(negedge clk);
    wr_start = 0; wr_done = 0; rd_start = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_wr_index", 0, a_wr_index[0], 0);
    check("rst_wr_addr",  0, a_wr_addr[0],  0);
    check("rst_rd_index", 0, a_rd_index[0], 2);
    check("rst_rd_addr",  0, a_rd_addr[0],  4147200);
    check("rst_rd_index", 1, a_rd_index[1], 1);
    check("rst_rd_addr",  1, a_rd_addr[1],  0);
    check("rst_rd_valid", 0, a_rd_valid[0], 0);

    cyc(1, 0, 0);
    check("alloc0_ack",   0, a_wr_ack[0],   1);
    check("alloc0_idx",   0, a_wr_index[0], 0);
    check("alloc0_addr",  0, a_wr_addr[0],  0);
    check("alloc0_rdidx", 0, a_rd_index[0], 2);
    check("alloc0_valid", 0, a_rd_valid[0], 0);
    cyc(0, 1, 0);
    check("pub_valid", 0, a_rd_valid[0], 1);
    cyc(0, 0, 1);
    check("read0_idx",  0, a_rd_index[0], 0);
    check("read0_addr", 0, a_rd_addr[0],  0);
    check("read0_addr", 1, a_rd_addr[1],  24'h100000);
    cyc(1, 0, 0);
    check("alloc1_idx",  0, a_wr_index[0], 1);
    check("alloc1_addr", 0, a_wr_addr[0],  2073600);
    check("alloc1_trunc", 1, a_wr_addr[1], 0);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    check("alloc2_idx",  0, a_wr_index[0], 2);
    check("steal_idx",   1, a_wr_index[1], 1);
`ifdef FRAME_BUF_STAT_EN
    check("steal_drop",  1, a_drop[1], 1);
`endif
    cyc(0, 1, 0);
`ifdef FRAME_BUF_STAT_EN
    check("overwrite_drop", 0, a_drop[0], 1);
`endif
    cyc(0, 0, 1);
    check("newest_idx", 0, a_rd_index[0], 2);
    check("newest_idx", 1, a_rd_index[1], 1);
    cyc(0, 0, 1);
    check("repeat_idx", 0, a_rd_index[0], 2);
`ifdef FRAME_BUF_STAT_EN
    check("repeat_cnt1", 0, a_rep[0], 1);
`endif
    cyc(1, 0, 0);
    check("alloc_after_read", 0, a_wr_index[0], 0);
    freeze = 1;
    cyc(0, 1, 0);
    freeze = 0;
    cyc(0, 0, 1);
    check("frozen_rd_idx", 0, a_rd_index[0], 2);
`ifdef FRAME_BUF_STAT_EN
    check("frozen_drop", 0, a_drop[0], 2);
    check("frozen_rep",  0, a_rep[0],  2);
`endif
    cyc(1, 0, 0);
    cyc(0, 1, 1);
    check("done_rd_same", 0, a_rd_index[0], 0);
    cyc(1, 0, 0);
    check("alloc_o", 0, a_wr_index[0], 1);
    cyc(1, 1, 0);
    check("done_wr_same", 0, a_wr_index[0], 2);
    check("done_wr_same", 1, a_wr_index[1], 1);
`ifdef FRAME_BUF_STAT_EN
    check("done_wr_drop", 1, a_drop[1], 3);
`endif
    cyc(1, 0, 0);
    check("abandon_idx", 0, a_wr_index[0], 2);
`ifdef FRAME_BUF_STAT_EN
    check("abandon_drop", 0, a_drop[0], 3);
`endif

    rst = 1; wr_start = 1;
    @(negedge clk);
    wr_start = 0; rst = 0;
    check("midrst_ack",   0, a_wr_ack[0],   0);
    check("midrst_widx",  0, a_wr_index[0], 0);
    check("midrst_ridx",  0, a_rd_index[0], 2);
    check("midrst_raddr", 0, a_rd_addr[0],  4147200);
    check("midrst_valid", 0, a_rd_valid[0], 0);
    cyc(0, 1, 0);
    check("ignored_done", 0, a_rd_valid[0], 0);
`ifdef FRAME_BUF_STAT_EN
    check("ignored_drop", 0, a_drop[0], 0);
`endif
    cyc(0, 0, 1);
    check("post_rst_rack", 0, a_rd_ack[0], 1);
    check("post_rst_ridx", 0, a_rd_index[0], 2);

`ifdef FRAME_BUF_STAT_EN
    rd_start = 1;
    repeat (65540) @(negedge clk);
    rd_start = 0;
    @(negedge clk);
    check("rep_saturate", 0, a_rep[0], 16'hFFFF);
    check("rep_saturate", 1, a_rep[1], 16'hFFFF);
`endif

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
